// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-unit types and constants (BTB_EN selects the branch predictor)
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped branch target buffer with 2-bit counters (built only when BTB_EN is defined)
module fetch_btb #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic              valid  [ENTRIES];
    logic [1:0]        ctr    [ENTRIES];
    logic [TAG_W-1:0]  tag    [ENTRIES];
    logic [31:0]       target [ENTRIES];

    logic [IDX_W-1:0]  l_idx, u_idx;
    logic [TAG_W-1:0]  l_tag, u_tag;
    logic              u_hit;
    logic              addr_unused;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];
    assign addr_unused = ^{lookup_pc[1:0], update_pc[1:0]};

    // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
    assign pred_taken  = valid[l_idx] && (tag[l_idx] == l_tag) && ctr[l_idx][1];
    assign pred_target = target[l_idx];
    assign u_hit       = valid[u_idx] && (tag[u_idx] == u_tag);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'd0;
            end
        end else if (update) begin
            if (u_hit) begin
                if (update_taken && ctr[u_idx] != 2'd3)
                    ctr[u_idx] <= ctr[u_idx] + 2'd1;
                else if (!update_taken && ctr[u_idx] != 2'd0)
                    ctr[u_idx] <= ctr[u_idx] - 2'd1;
            end else if (update_taken) begin
                valid[u_idx] <= 1'b1;
                ctr[u_idx]   <= 2'd2;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (update && (u_hit || update_taken)) begin
            tag[u_idx]    <= u_tag;
            target[u_idx] <= update_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with skid buffer, flush drain and optional BTB (macro BTB_EN)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF,
    output logic        INSTR_VALID,
    input  logic        BP_UPDATE,
    input  logic [31:0] BP_UPDATE_PC,
    input  logic        BP_TAKEN,
    input  logic [31:0] BP_TARGET
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_next, drain_addr;
    logic [31:0]  skid_data, skid_pc, skid_next;

`ifdef BTB_EN
    logic        pred_taken;
    logic [31:0] pred_target;

    fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .CLK           (CLK),
        .RESET         (RESET),
        .lookup_pc     (pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .update        (BP_UPDATE),
        .update_pc     (BP_UPDATE_PC),
        .update_taken  (BP_TAKEN),
        .update_target (BP_TARGET)
    );

    assign pc_next = pred_taken ? pred_target : pc + 32'd4;
`else
    logic bp_unused;
    assign bp_unused = ^{BP_UPDATE, BP_UPDATE_PC, BP_TAKEN, BP_TARGET, 32'(BTB_ENTRIES)};
    assign pc_next   = pc + 32'd4;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        IMEM_REQ  = 1'b1;
        IMEM_ADDR = pc;
        case (state)
            ST_FETCH: begin
                if (FLUSH)                 state_nx = IMEM_ACK ? ST_FETCH : ST_DRAIN;
                else if (IMEM_ACK && STALL) state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                IMEM_REQ = 1'b0;
                if (FLUSH || !STALL) state_nx = ST_FETCH;
            end
            ST_DRAIN: begin
                // The abandoned request must complete at its original address.
                IMEM_ADDR = drain_addr;
                if (IMEM_ACK) state_nx = ST_FETCH;
            end
            default: state_nx = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc                <= RESET_PC;
            drain_addr        <= RESET_PC;
            skid_data         <= NOP;
            skid_pc           <= NOP;
            skid_next         <= NOP;
            Instr1_IF         <= NOP;
            Instr_PC_IF       <= NOP;
            Instr_PC_Plus4_IF <= NOP;
            INSTR_VALID       <= 1'b0;
        end else if (FLUSH) begin
            pc                <= FLUSH_PC;
            skid_data         <= NOP;
            skid_pc           <= NOP;
            skid_next         <= NOP;
            Instr1_IF         <= NOP;
            Instr_PC_IF       <= NOP;
            Instr_PC_Plus4_IF <= NOP;
            INSTR_VALID       <= 1'b0;
            if (state == ST_FETCH && !IMEM_ACK) drain_addr <= pc;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (IMEM_ACK) begin
                        pc <= pc_next;
                        if (STALL) begin
                            skid_data <= IMEM_DATA;
                            skid_pc   <= pc;
                            skid_next <= pc_next;
                        end else begin
                            Instr1_IF         <= IMEM_DATA;
                            Instr_PC_IF       <= pc;
                            Instr_PC_Plus4_IF <= pc_next;
                            INSTR_VALID       <= 1'b1;
                        end
                    end else if (!STALL) begin
                        // Downstream consumes every unstalled cycle: present a bubble.
                        INSTR_VALID <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!STALL) begin
                        Instr1_IF         <= skid_data;
                        Instr_PC_IF       <= skid_pc;
                        Instr_PC_Plus4_IF <= skid_next;
                        INSTR_VALID       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'hBFC0_0000;
    localparam int          BTB_N   = 16;
    localparam int          BTB_LOG = 4;

    logic        CLK = 1'b0;
    logic        RESET, STALL, FLUSH, IMEM_ACK, BP_UPDATE, BP_TAKEN;
    logic [31:0] FLUSH_PC, IMEM_DATA, BP_UPDATE_PC, BP_TARGET;
    logic        IMEM_REQ, INSTR_VALID;
    logic [31:0] IMEM_ADDR, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF;

    fetch_unit #(.RESET_PC(RST_PC), .BTB_ENTRIES(BTB_N)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .FLUSH             (FLUSH),
        .FLUSH_PC          (FLUSH_PC),
        .IMEM_REQ          (IMEM_REQ),
        .IMEM_ADDR         (IMEM_ADDR),
        .IMEM_ACK          (IMEM_ACK),
        .IMEM_DATA         (IMEM_DATA),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
        .INSTR_VALID       (INSTR_VALID),
        .BP_UPDATE         (BP_UPDATE),
        .BP_UPDATE_PC      (BP_UPDATE_PC),
        .BP_TAKEN          (BP_TAKEN),
        .BP_TARGET         (BP_TARGET)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic [31:0] p;
        logic [31:0] n;
    } ent_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc, m_daddr;
    bit          m_discard;
    bit          m_valid;
    ent_t        m_out;
    ent_t        m_skid[$];

    bit          bv   [BTB_N];
    logic [31:0] btag [BTB_N];
    logic [31:0] btgt [BTB_N];
    int          bctr [BTB_N];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] predict(input logic [31:0] a);
        int unsigned i = 32'((a >> 2) % BTB_N);
`ifdef BTB_EN
        if (bv[i] && btag[i] == (a >> (2 + BTB_LOG)) && bctr[i] >= 2) return btgt[i];
`else
        if (i > BTB_N) return 32'h0;
`endif
        return a + 32'd4;
    endfunction

    task automatic train(input logic [31:0] a, input bit taken, input logic [31:0] tgt);
        int unsigned i = 32'((a >> 2) % BTB_N);
        if (bv[i] && btag[i] == (a >> (2 + BTB_LOG))) begin
            bctr[i] = taken ? ((bctr[i] < 3) ? bctr[i] + 1 : 3) : ((bctr[i] > 0) ? bctr[i] - 1 : 0);
            btgt[i] = tgt;
        end else if (taken) begin
            bv[i] = 1; btag[i] = a >> (2 + BTB_LOG); btgt[i] = tgt; bctr[i] = 2;
        end
    endtask

    task automatic reset_model();
        m_pc = RST_PC; m_daddr = RST_PC; m_discard = 0; m_valid = 0;
        m_out = '{32'h0, 32'h0, 32'h0};
        m_skid.delete();
        for (int i = 0; i < BTB_N; i++) begin bv[i] = 0; bctr[i] = 0; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a falling edge; checks request outputs before the edge and Instr outputs after it.
    task automatic step(input bit st, input bit fl, input logic [31:0] fpc, input bit ak);
        bit          req, ack;
        logic [31:0] addr;
        ent_t        e;
        STALL = st; FLUSH = fl; FLUSH_PC = fpc;
        req  = (m_skid.size() == 0);
        addr = m_discard ? m_daddr : m_pc;
        ack  = ak && req;
        IMEM_ACK  = ack;
        IMEM_DATA = mem_word(IMEM_ADDR);
        #1;
        chk("imem_req", IMEM_REQ, req);
        if (req) chk("imem_addr", IMEM_ADDR, addr);
        if (fl) begin
            if (!m_discard && req && !ack) begin m_discard = 1; m_daddr = m_pc; end
            else if (m_discard && ack) m_discard = 0;
            m_skid.delete();
            m_out = '{32'h0, 32'h0, 32'h0};
            m_valid = 0;
            m_pc = fpc;
        end else if (m_discard) begin
            if (ack) m_discard = 0;
        end else if (m_skid.size() != 0) begin
            if (!st) begin m_out = m_skid.pop_front(); m_valid = 1; end
        end else if (ack) begin
            e = '{mem_word(m_pc), m_pc, predict(m_pc)};
            m_pc = e.n;
            if (st) m_skid.push_back(e);
            else begin m_out = e; m_valid = 1; end
        end else if (!st) begin
            m_valid = 0;
        end
        if (BP_UPDATE) train(BP_UPDATE_PC, BP_TAKEN, BP_TARGET);
        @(posedge CLK); #1;
        chk("instr", Instr1_IF, m_out.d);
        chk("instr_pc", Instr_PC_IF, m_out.p);
        chk("instr_next", Instr_PC_Plus4_IF, m_out.n);
        chk("instr_valid", INSTR_VALID, m_valid);
        @(negedge CLK);
        IMEM_ACK = 0;
    endtask

    initial begin
        RESET = 0; STALL = 0; FLUSH = 0; FLUSH_PC = 0; IMEM_ACK = 0; IMEM_DATA = 0;
        BP_UPDATE = 0; BP_UPDATE_PC = 0; BP_TAKEN = 0; BP_TARGET = 0;
        reset_model();
        repeat (2) @(negedge CLK);
        chk("rst_instr", Instr1_IF, 32'h0);
        chk("rst_pc", Instr_PC_IF, 32'h0);
        chk("rst_next", Instr_PC_Plus4_IF, 32'h0);
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_req", IMEM_REQ, 1'b1);
        chk("rst_addr", IMEM_ADDR, RST_PC);
        RESET = 1;

        // Back-to-back single-cycle fetches
        step(0, 0, 0, 1);
        chk("seq_pc0", Instr_PC_IF, 32'hBFC0_0000);
        chk("seq_next0", Instr_PC_Plus4_IF, 32'hBFC0_0004);
        chk("seq_addr1", IMEM_ADDR, 32'hBFC0_0004);
        step(0, 0, 0, 1);
        chk("seq_pc1", Instr_PC_IF, 32'hBFC0_0004);
        chk("seq_addr2", IMEM_ADDR, 32'hBFC0_0008);

        // Three-cycle stall with ACK at BFC00008
        step(1, 0, 0, 1);
        chk("stall_hold_pc", Instr_PC_IF, 32'hBFC0_0004);
        chk("stall_req_low", IMEM_REQ, 1'b0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("stall_hold_pc3", Instr_PC_IF, 32'hBFC0_0004);
        step(0, 0, 0, 1);
        chk("unstall_pc", Instr_PC_IF, 32'hBFC0_0008);
        chk("unstall_instr", Instr1_IF, mem_word(32'hBFC0_0008));
        chk("unstall_addr", IMEM_ADDR, 32'hBFC0_000C);
        step(0, 0, 0, 1);
        chk("after_hold_pc", Instr_PC_IF, 32'hBFC0_000C);

        // Flush while the response is two cycles late
        step(0, 1, 32'h8000_0100, 0);
        chk("drain_addr", IMEM_ADDR, 32'hBFC0_0010);
        chk("drain_valid", INSTR_VALID, 1'b0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("drain_discard_valid", INSTR_VALID, 1'b0);
        chk("drain_discard_instr", Instr1_IF, 32'h0);
        chk("drain_next_addr", IMEM_ADDR, 32'h8000_0100);

        // Flush wins over stall and ack
        step(0, 0, 0, 1);
        step(1, 1, 32'h9000_0000, 1);
        chk("flush_stall_instr", Instr1_IF, 32'h0);
        chk("flush_stall_valid", INSTR_VALID, 1'b0);
        chk("flush_stall_addr", IMEM_ADDR, 32'h9000_0000);

        // Address wrap at the top of memory
        step(0, 1, 32'hFFFF_FFF8, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("wrap_pc", Instr_PC_IF, 32'hFFFF_FFFC);
        chk("wrap_next", Instr_PC_Plus4_IF, 32'h0);
        chk("wrap_addr", IMEM_ADDR, 32'h0);

        // Reset with a request outstanding
        RESET = 0;
        #1;
        chk("midrst_valid", INSTR_VALID, 1'b0);
        chk("midrst_addr", IMEM_ADDR, RST_PC);
        @(negedge CLK);
        RESET = 1;
        reset_model();
        step(0, 0, 0, 1);
        chk("midrst_first_pc", Instr_PC_IF, RST_PC);

`ifdef BTB_EN
        BP_UPDATE = 1; BP_UPDATE_PC = 32'hBFC0_0010; BP_TAKEN = 1; BP_TARGET = 32'hBFC0_0100;
        step(0, 0, 0, 0);
        BP_UPDATE = 0;
        step(0, 1, 32'hBFC0_0010, 1);
        step(0, 0, 0, 1);
        chk("btb_taken_next", Instr_PC_Plus4_IF, 32'hBFC0_0100);
        chk("btb_taken_addr", IMEM_ADDR, 32'hBFC0_0100);
        BP_UPDATE = 1; BP_TAKEN = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        BP_UPDATE = 0;
        step(0, 1, 32'hBFC0_0010, 1);
        step(0, 0, 0, 1);
        chk("btb_nt_next", Instr_PC_Plus4_IF, 32'hBFC0_0014);
`endif

        for (int k = 0; k < 400; k++) begin
            step(($urandom % 10) < 3, ($urandom % 20) == 0,
                 $urandom & 32'hFFFF_FFFC, ($urandom % 10) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
